// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - cascaded BCD down-counter with run/pause/idle control and done pulse
// Optional add-30-seconds feature enabled by defining BCD_TIMER_ADD30_EN.
module bcd_down_timer #(
  parameter int                 DIGITS    = 4,
  parameter logic [DIGITS-1:0]  MOD6_MASK = 4'b0010
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
`ifdef BCD_TIMER_ADD30_EN
  input  logic                  add30,
`endif
  output logic [4*DIGITS-1:0]   out,
  output logic                  zero,
  output logic                  running,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t              state;
  logic [4*DIGITS-1:0] clamped;
  logic [4*DIGITS-1:0] dec;
  logic                borrow;

  function automatic logic [3:0] dmax(input int i);
    return MOD6_MASK[i] ? 4'd5 : 4'd9;
  endfunction

  always_comb begin
    clamped = data;
    for (int i = 0; i < DIGITS; i++) begin
      if (data[4*i +: 4] > dmax(i))
        clamped[4*i +: 4] = dmax(i);
    end
  end

  // Borrow ripples from digit 0 upward; a digit at 0 reloads its maximum.
  always_comb begin
    dec    = out;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (out[4*i +: 4] == 4'd0) begin
          dec[4*i +: 4] = dmax(i);
        end else begin
          dec[4*i +: 4] = out[4*i +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
  end

`ifdef BCD_TIMER_ADD30_EN
  logic [4*DIGITS-1:0] added;
  logic                carry;
  logic [4:0]          sum;
  logic [4:0]          wrapped;

  // +3 on digit 1, carry upward; carry out of the top digit saturates everything.
  always_comb begin
    added   = out;
    carry   = 1'b0;
    sum     = '0;
    wrapped = '0;
    for (int i = 1; i < DIGITS; i++) begin
      sum     = {1'b0, out[4*i +: 4]} + {4'b0, carry} + ((i == 1) ? 5'd3 : 5'd0);
      wrapped = sum - {1'b0, dmax(i)} - 5'd1;
      if (sum > {1'b0, dmax(i)}) begin
        added[4*i +: 4] = wrapped[3:0];
        carry           = 1'b1;
      end else begin
        added[4*i +: 4] = sum[3:0];
        carry           = 1'b0;
      end
    end
    if (carry) begin
      for (int i = 0; i < DIGITS; i++)
        added[4*i +: 4] = dmax(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (clr) begin
      out     <= '0;
      zero    <= 1'b1;
      running <= 1'b0;
      state   <= IDLE;
    end else if (load && state != RUN) begin
      out     <= clamped;
      zero    <= (clamped == '0);
      running <= 1'b0;
      state   <= IDLE;
    end
`ifdef BCD_TIMER_ADD30_EN
    else if (add30) begin
      out  <= added;
      zero <= (added == '0);
      if (state == IDLE) begin
        state   <= RUN;
        running <= 1'b1;
      end
    end
`endif
    else if (pause && state == RUN) begin
      state   <= PAUSE;
      running <= 1'b0;
    end else if (start && state != RUN && out != '0) begin
      state   <= RUN;
      running <= 1'b1;
    end else if (tick && state == RUN && out != '0) begin
      out  <= dec;
      zero <= (dec == '0);
      if (dec == '0) begin
        done    <= 1'b1;
        running <= 1'b0;
        state   <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb/tb_bcd_down_timer.sv - directed self-checking bench for bcd_down_timer
module tb_bcd_down_timer;
  logic        clk = 1'b0;
  logic        clr, load, start, pause, tick;
  logic [15:0] data;
  logic [15:0] out;
  logic        zero, running, done;
`ifdef BCD_TIMER_ADD30_EN
  logic        add30;
`endif
  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  bcd_down_timer dut (
    .clk(clk), .clr(clr), .data(data), .load(load), .start(start),
    .pause(pause), .tick(tick),
`ifdef BCD_TIMER_ADD30_EN
    .add30(add30),
`endif
    .out(out), .zero(zero), .running(running), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
    clr = 0; load = 0; start = 0; pause = 0; tick = 0;
`ifdef BCD_TIMER_ADD30_EN
    add30 = 0;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_out, input logic e_zero,
                         input logic e_run, input logic e_done);
    chk({tag, ".out"}, 32'(out), 32'(e_out));
    chk({tag, ".zero"}, 32'(zero), 32'(e_zero));
    chk({tag, ".running"}, 32'(running), 32'(e_run));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  initial begin
    clr = 1; load = 0; start = 0; pause = 0; tick = 0; data = '0;
`ifdef BCD_TIMER_ADD30_EN
    add30 = 0;
`endif
    step();
    chk_all("reset", 16'h0000, 1, 0, 0);

    // clr mid-run at 12:34
    data = 16'h1234; load = 1; step();
    start = 1; step();
    chk_all("run1234", 16'h1234, 0, 1, 0);
    tick = 1; step();
    chk_all("tick1233", 16'h1233, 0, 1, 0);
    clr = 1; tick = 1; step();
    chk_all("clr_mid_run", 16'h0000, 1, 0, 0);
    tick = 1; step();
    chk_all("tick_after_clr", 16'h0000, 1, 0, 0);

    // 01:05 -> five ticks -> 01:00 -> 00:59
    data = 16'h0105; load = 1; step();
    chk_all("load0105", 16'h0105, 0, 0, 0);
    start = 1; step();
    for (int i = 0; i < 5; i++) begin
      tick = 1; step();
    end
    chk_all("tick0100", 16'h0100, 0, 1, 0);
    tick = 1; step();
    chk_all("borrow0059", 16'h0059, 0, 1, 0);

    // expiry from 00:01
    pause = 1; step();
    chk("pause_running", 32'(running), 32'd0);
    data = 16'h0001; load = 1; step();
    chk_all("load0001", 16'h0001, 0, 0, 0);
    start = 1; step();
    tick = 1; step();
    chk_all("expire", 16'h0000, 1, 0, 1);
    step();
    chk_all("done_drop", 16'h0000, 1, 0, 0);
    tick = 1; step();
    chk_all("no_wrap", 16'h0000, 1, 0, 0);

    // pause + tick same edge, resume
    data = 16'h0010; load = 1; step();
    start = 1; step();
    pause = 1; tick = 1; step();
    chk_all("pause_tick", 16'h0010, 0, 0, 0);
    tick = 1; step();
    chk_all("tick_paused", 16'h0010, 0, 0, 0);
    start = 1; step();
    chk_all("resume", 16'h0010, 0, 1, 0);
    tick = 1; step();
    chk_all("tick0009", 16'h0009, 0, 1, 0);

    // load ignored in RUN, start ignored at zero, clamp
    data = 16'h5555; load = 1; step();
    chk_all("load_in_run", 16'h0009, 0, 1, 0);
    clr = 1; step();
    start = 1; step();
    chk_all("start_at_zero", 16'h0000, 1, 0, 0);
    data = 16'h9F7A; load = 1; step();
    chk_all("clamp", 16'h9959, 0, 0, 0);
    start = 1; step();
    tick = 1; step();
    chk_all("tick9958", 16'h9958, 0, 1, 0);

`ifdef BCD_TIMER_ADD30_EN
    clr = 1; step();
    add30 = 1; step();
    chk_all("add30_idle", 16'h0030, 0, 1, 0);
    pause = 1; step();
    data = 16'h0045; load = 1; step();
    add30 = 1; tick = 1; step();
    chk_all("add30_0045", 16'h0115, 0, 1, 0);
    pause = 1; step();
    data = 16'h9945; load = 1; step();
    add30 = 1; step();
    chk_all("add30_sat", 16'h9959, 0, 1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/bcd_down_timer.md
# bcd_down_timer

Parametrised cascaded BCD down-counter for the microwave cook timer, replacing the chain of single-digit mod-10 counters with one block. Holds DIGITS BCD digits, each independently mod-10 or mod-6, so the default build counts MM:SS. Adds a run/pause/idle state machine, saturation at zero instead of wrap-around, and a one-cycle done pulse for the control FSM and buzzer logic. Sits between the keypad/load path and the display driver; `tick` comes from the 1 Hz prescaler.

## Interface
- DIGITS, 4, number of BCD digits; digit 0 is least significant; minimum 2.
- MOD6_MASK, 4'b0010 (DIGITS bits), bit i set means digit i counts 5..0 (seconds tens); clear means 9..0.

- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  reset; one clock, synchronous and active-high, highest priority.
- data  in  4*DIGITS  BCD preset value, digit i at bits [4i+3:4i].
- load  in  1  load `data` into the count.
- start  in  1  start or resume counting.
- pause  in  1  suspend counting.
- tick  in  1  one-cycle decrement strobe.
- add30  in  1  add 30 s; present only with BCD_TIMER_ADD30_EN.
- out  out  4*DIGITS  current BCD count.
- zero  out  1  high when `out` is all zeros.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse when RUN reaches zero.

## Operation
- States: IDLE, RUN, PAUSE. `running` = (state==RUN).
- Reset (`clr`=1 at edge): out=0, zero=1, running=0, done=0, state=IDLE. This applies in any state, including mid-count.
- Priority per edge: clr > load > add30 > pause > start > tick.
- load:
  - Accepted in IDLE or PAUSE, ignored in RUN.
  - Next state is IDLE.
  - Any digit above its maximum (9, or 5 for mask digits) is clamped to that maximum.
- start:
  - From IDLE or PAUSE with count≠0, go to RUN.
  - With count=0, ignored.
  - In RUN, no effect.
- pause:
  - In RUN, go to PAUSE.
  - Otherwise ignored.
  - pause and start together in RUN: go to PAUSE.
- tick:
  - Acts only in RUN and only when no higher-priority input is active.
  - Decrements the count by one with borrow ripple: a digit at 0 reloads its maximum and borrows from the next digit.
  - Ticks in IDLE or PAUSE are dropped, not queued.
- Terminal: a tick in RUN with count = 1 (digit 0 = 1, all others 0) makes out=0, zero=1, done=1, state=IDLE.
- Count never wraps below zero.
- `zero` always equals (out==0) as registered; it is never stale.
- `done` is high for exactly one cycle per expiry. It is never asserted by load, clr or a zero preset.

## Timing
- All outputs are registered; every input takes effect at the next rising edge.
- load → `out`/`zero` valid 1 cycle later.
- start → `running`=1 1 cycle later. The first decrement occurs on the first tick after that.
- Expiry tick → out=0, zero=1, done=1, running=0, all on the same edge. `done` deasserts on the following edge.
- Borrow ripple across all DIGITS completes in one cycle (combinational borrow chain).

## Configuration
- BCD_TIMER_ADD30_EN defined: `add30` port exists.
  - Adds 30 s: digit 1 += 3, carrying into digit 2 upward (mod-6/mod-10 per mask).
  - Saturates at all digits at their maximum (99:59 default).
  - Accepted in every state. From IDLE, also enters RUN.
  - A tick on the same edge is dropped.
  - Does not change PAUSE or RUN state.
- Not defined: no `add30` port and no add-30 logic. All other behaviour is identical.

## Test plan
- clr mid-RUN at 12:34 → next cycle out=0000, zero=1, running=0, done=0, state IDLE.
- load 0x0105 (01:05) then start, apply 5 ticks → 01:00. Next tick → 00:59, showing the mod-6 borrow and digit 0 reloading 9.
- load 0x0001, start, one tick → out=0, zero=1, done high exactly one cycle, running=0. A further tick leaves out at 0 and raises no done.
- RUN at 00:10, pause and tick on the same edge → PAUSE, out stays 00:10. Ticks while paused are ignored. start → RUN, next tick → 00:09.
- load 0x9F7A → clamped to 99:59. load asserted during RUN → ignored. start with count 0 → stays IDLE.
- With BCD_TIMER_ADD30_EN:
  - IDLE at 0, add30 → 00:30 and RUN.
  - At 00:45, add30 → 01:15.
  - At 99:45, add30 → 99:59.
